// File: rtl/boreal_action_gate.sv
// Responder side of the decision-VM action interface: captures one action,
// validates it against the fixed policy, and returns one response per capture.
module boreal_action_gate #(
    parameter logic [31:0] POLICY_HASH = 32'hA5A5_0001,
    parameter logic [31:0] ARG_MAX     = 32'd100,
    parameter logic [31:0] TARGET_LO   = 32'h10,
    parameter logic [31:0] TARGET_HI   = 32'h1F,
    parameter logic [31:0] OPCODE_MASK = 32'h0000_0002,
    parameter logic [31:0] MIN_GAP     = 32'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act_valid,
    input  logic [511:0] act_data,
    output logic         gate_resp_valid,
    output logic [159:0] gate_resp_data,
    output logic         cmd_valid,
    output logic [31:0]  cmd_target,
    output logic [31:0]  cmd_arg0,
    output logic [31:0]  cmd_arg1,
    output logic [15:0]  accept_cnt,
    output logic [15:0]  reject_cnt,
    output logic [15:0]  drop_cnt
);
    // state | meaning
    // IDLE  | waiting for an action pulse
    // CHECK | evaluating the latched action
    // RESP  | response (and command on accept) strobe
    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    localparam logic [7:0] ST_ACCEPT    = 8'h00;
    localparam logic [7:0] ST_MALFORMED = 8'h01;
    localparam logic [7:0] ST_POLICY    = 8'h02;
    localparam logic [7:0] ST_REPLAY    = 8'h03;
    localparam logic [7:0] ST_EXHAUSTED = 8'h04;
    localparam logic [7:0] ST_OPCODE    = 8'h05;
    localparam logic [7:0] ST_TARGET    = 8'h06;
    localparam logic [7:0] ST_BOUNDS    = 8'h07;
    localparam logic [7:0] ST_RATE      = 8'h08;
    localparam logic [7:0] ST_CLAMPED   = 8'h10;

    state_t       state, next_state;
    logic [511:0] act_q;
    logic [7:0]   status, status_q;
    logic [31:0]  eff_arg0;
    logic         acc_q;
    logic [31:0]  expected_nonce;
    logic         exhausted;
    logic [31:0]  gap_cnt;

    logic [31:0] f_opcode, f_target, f_arg0, f_arg1, f_hash, f_bounds, f_nonce;
    assign f_opcode = act_q[31:0];
    assign f_target = act_q[63:32];
    assign f_arg0   = act_q[95:64];
    assign f_arg1   = act_q[127:96];
    assign f_hash   = act_q[191:160];
    assign f_bounds = act_q[223:192];
    assign f_nonce  = act_q[255:224];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (act_valid) next_state = CHECK;
            CHECK:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gate_resp_valid = (state == RESP);
        cmd_valid       = (state == RESP) && acc_q;
    end

    // Gap counter saturates at MIN_GAP, so "below MIN_GAP" reduces to inequality.
    always_comb begin
        status   = ST_ACCEPT;
        eff_arg0 = f_arg0;
        if ((|act_q[159:128]) || (|act_q[511:256]) || (f_bounds > 32'd1))
            status = ST_MALFORMED;
        else if (f_hash != POLICY_HASH)
            status = ST_POLICY;
        else if (exhausted)
            status = ST_EXHAUSTED;
        else if (f_nonce < expected_nonce)
            status = ST_REPLAY;
        else if ((|f_opcode[31:5]) || !OPCODE_MASK[f_opcode[4:0]])
            status = ST_OPCODE;
        else if ((f_target < TARGET_LO) || (f_target > TARGET_HI))
            status = ST_TARGET;
        else if ((f_arg0 > ARG_MAX) && f_bounds[0])
            status = ST_BOUNDS;
        else if (gap_cnt != MIN_GAP)
            status = ST_RATE;
        else if (f_arg0 > ARG_MAX) begin
            status   = ST_CLAMPED;
            eff_arg0 = ARG_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q          <= '0;
            status_q       <= '0;
            acc_q          <= 1'b0;
            gate_resp_data <= '0;
            cmd_target     <= '0;
            cmd_arg0       <= '0;
            cmd_arg1       <= '0;
            accept_cnt     <= '0;
            reject_cnt     <= '0;
            drop_cnt       <= '0;
            expected_nonce <= '0;
            exhausted      <= 1'b0;
            gap_cnt        <= MIN_GAP;
        end else begin
            if (state == IDLE && act_valid)
                act_q <= act_data;
            if (state != IDLE && act_valid && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            if (state == RESP && acc_q)
                gap_cnt <= '0;
            else if (gap_cnt != MIN_GAP)
                gap_cnt <= gap_cnt + 32'd1;

            if (state == CHECK) begin
                status_q       <= status;
                acc_q          <= (status == ST_ACCEPT) || (status == ST_CLAMPED);
                gate_resp_data <= {eff_arg0, f_target, f_opcode, f_nonce, 24'd0, status};
                if ((status == ST_ACCEPT) || (status == ST_CLAMPED)) begin
                    cmd_target <= f_target;
                    cmd_arg0   <= eff_arg0;
                    cmd_arg1   <= f_arg1;
                end
            end

            if (state == RESP) begin
                if (acc_q) begin
                    if (accept_cnt != 16'hFFFF) accept_cnt <= accept_cnt + 16'd1;
                end else begin
                    if (reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
                end
                if (status_q != ST_MALFORMED && status_q != ST_POLICY &&
                    status_q != ST_REPLAY && status_q != ST_EXHAUSTED) begin
                    if (f_nonce == 32'hFFFF_FFFF) begin
                        expected_nonce <= 32'hFFFF_FFFF;
                        exhausted      <= 1'b1;
                    end else begin
                        expected_nonce <= f_nonce + 32'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_boreal_action_gate.sv
// Directed bench for boreal_action_gate: vector table plus multi-cycle sequences.
module tb_boreal_action_gate;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         act_valid = 1'b0;
    logic [511:0] act_data = '0;
    logic         g_valid = 1'b0;
    logic [511:0] g_data = '0;

    logic         resp_valid, cmd_valid, g_resp_valid, g_cmd_valid;
    logic [159:0] resp_data, g_resp_data;
    logic [31:0]  cmd_target, cmd_arg0, cmd_arg1, g_cmd_target, g_cmd_arg0, g_cmd_arg1;
    logic [15:0]  accept_cnt, reject_cnt, drop_cnt, g_accept_cnt, g_reject_cnt, g_drop_cnt;

    int errors = 0;
    int checks = 0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    boreal_action_gate dut (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_data(act_data),
        .gate_resp_valid(resp_valid), .gate_resp_data(resp_data),
        .cmd_valid(cmd_valid), .cmd_target(cmd_target), .cmd_arg0(cmd_arg0),
        .cmd_arg1(cmd_arg1), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt),
        .drop_cnt(drop_cnt));

    boreal_action_gate #(.MIN_GAP(32'd4)) dut_gap (
        .clk(clk), .rst(rst), .act_valid(g_valid), .act_data(g_data),
        .gate_resp_valid(g_resp_valid), .gate_resp_data(g_resp_data),
        .cmd_valid(g_cmd_valid), .cmd_target(g_cmd_target), .cmd_arg0(g_cmd_arg0),
        .cmd_arg1(g_cmd_arg1), .accept_cnt(g_accept_cnt), .reject_cnt(g_reject_cnt),
        .drop_cnt(g_drop_cnt));

    logic         m_rv, m_cv;
    logic [159:0] m_rd;
    logic [31:0]  m_ct, m_ca0, m_ca1;
    assign m_rv  = sel ? g_resp_valid : resp_valid;
    assign m_cv  = sel ? g_cmd_valid  : cmd_valid;
    assign m_rd  = sel ? g_resp_data  : resp_data;
    assign m_ct  = sel ? g_cmd_target : cmd_target;
    assign m_ca0 = sel ? g_cmd_arg0   : cmd_arg0;
    assign m_ca1 = sel ? g_cmd_arg1   : cmd_arg1;

    localparam logic [31:0] HASH = 32'hA5A5_0001;

    typedef struct {
        logic [511:0] data;
        logic [31:0]  status;
        logic [31:0]  arg0;
        logic         cmd;
    } vec_t;

    function automatic logic [511:0] mk(input logic [31:0] op, input logic [31:0] tgt,
                                        input logic [31:0] a0, input logic [31:0] hash,
                                        input logic [31:0] bnd, input logic [31:0] nonce);
        logic [511:0] d;
        d = '0;
        d[31:0]    = op;
        d[63:32]   = tgt;
        d[95:64]   = a0;
        d[127:96]  = 32'hC0DE_0000 ^ nonce;
        d[191:160] = hash;
        d[223:192] = bnd;
        d[255:224] = nonce;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Drive one action in cycle T and check the response lands at exactly T+2.
    task automatic do_action(input logic s, input logic [511:0] d, input logic [31:0] st,
                             input logic [31:0] a0, input logic cmd);
        sel = s;
        @(posedge clk); #1;
        if (s) begin g_valid = 1'b1; g_data = d; end
        else   begin act_valid = 1'b1; act_data = d; end
        @(posedge clk); #1;
        g_valid = 1'b0; act_valid = 1'b0;
        @(negedge clk);
        chk("resp_early", {63'd0, m_rv}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("resp_valid", {63'd0, m_rv}, 64'd1);
        chk("status", {32'd0, m_rd[31:0]}, {32'd0, st});
        chk("nonce_echo", {32'd0, m_rd[63:32]}, {32'd0, d[255:224]});
        chk("opcode_echo", {32'd0, m_rd[95:64]}, {32'd0, d[31:0]});
        chk("target_echo", {32'd0, m_rd[127:96]}, {32'd0, d[63:32]});
        chk("eff_arg0", {32'd0, m_rd[159:128]}, {32'd0, a0});
        chk("cmd_valid", {63'd0, m_cv}, {63'd0, cmd});
        if (cmd) begin
            chk("cmd_target", {32'd0, m_ct}, {32'd0, d[63:32]});
            chk("cmd_arg0", {32'd0, m_ca0}, {32'd0, a0});
            chk("cmd_arg1", {32'd0, m_ca1}, {32'd0, d[127:96]});
        end
    endtask

    vec_t vecs[14];
    logic [511:0] tmp;
    int exp_acc, exp_rej;
    logic [31:0] last_tgt, last_a0;

    initial begin
        tmp = mk(1, 32'h10, 50, 32'h1234_5678, 0, 4); tmp[300] = 1'b1;
        vecs[0]  = '{mk(1, 32'h10, 50, HASH, 0, 0), 32'h00, 50, 1'b1};
        vecs[1]  = '{mk(1, 32'h11, 300, HASH, 0, 1), 32'h10, 100, 1'b1};
        vecs[2]  = '{mk(1, 32'h11, 300, HASH, 1, 2), 32'h07, 300, 1'b0};
        vecs[3]  = '{mk(1, 32'h12, 50, HASH, 0, 3), 32'h00, 50, 1'b1};
        vecs[4]  = '{mk(7, 32'h10, 50, 32'hDEAD_BEEF, 0, 4), 32'h02, 50, 1'b0};
        vecs[5]  = '{mk(2, 32'h10, 50, HASH, 0, 4), 32'h05, 50, 1'b0};
        vecs[6]  = '{mk(1, 32'h20, 50, HASH, 0, 5), 32'h06, 50, 1'b0};
        vecs[7]  = '{tmp, 32'h01, 50, 1'b0};
        vecs[8]  = '{mk(1, 32'h10, 50, HASH, 2, 6), 32'h01, 50, 1'b0};
        vecs[9]  = '{mk(1, 32'h10, 50, HASH, 0, 3), 32'h03, 50, 1'b0};
        vecs[10] = '{mk(33, 32'h10, 50, HASH, 0, 6), 32'h05, 50, 1'b0};
        vecs[11] = '{mk(1, 32'h1F, 100, HASH, 1, 7), 32'h00, 100, 1'b1};
        vecs[12] = '{mk(1, 32'h0F, 50, HASH, 0, 8), 32'h06, 50, 1'b0};
        tmp = mk(1, 32'h10, 50, HASH, 0, 9); tmp[128] = 1'b1;
        vecs[13] = '{tmp, 32'h01, 50, 1'b0};

        do_reset();
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data[31:0]}, 64'd0);
        chk("rst_cmd_target", {32'd0, cmd_target}, 64'd0);
        chk("rst_counters", {16'd0, accept_cnt, reject_cnt, drop_cnt}, 64'd0);

        exp_acc = 0; exp_rej = 0; last_tgt = 0; last_a0 = 0;
        for (int i = 0; i < 14; i++) begin
            do_action(1'b0, vecs[i].data, vecs[i].status, vecs[i].arg0, vecs[i].cmd);
            if (vecs[i].cmd) begin
                exp_acc++; last_tgt = vecs[i].data[63:32]; last_a0 = vecs[i].arg0;
            end else begin
                exp_rej++;
                chk("cmd_target_hold", {32'd0, cmd_target}, {32'd0, last_tgt});
                chk("cmd_arg0_hold", {32'd0, cmd_arg0}, {32'd0, last_a0});
            end
        end
        @(posedge clk); @(negedge clk);
        chk("accept_cnt", {48'd0, accept_cnt}, 64'(exp_acc));
        chk("reject_cnt", {48'd0, reject_cnt}, 64'(exp_rej));
        chk("resp_data_hold", {32'd0, resp_data[63:32]}, 64'd9);

        // Nonce sequence 0,1,1,5,3 leaves expected_nonce at 6.
        do_reset();
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 0), 32'h00, 10, 1'b1);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 1), 32'h00, 10, 1'b1);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 1), 32'h03, 10, 1'b0);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 5), 32'h00, 10, 1'b1);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 3), 32'h03, 10, 1'b0);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 5), 32'h03, 10, 1'b0);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 6), 32'h00, 10, 1'b1);

        // Nonce exhaustion persists until reset.
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 32'hFFFF_FFFF), 32'h00, 10, 1'b1);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 32'hFFFF_FFFF), 32'h04, 10, 1'b0);
        do_reset();
        @(negedge clk);
        chk("rst_accept_cnt", {48'd0, accept_cnt}, 64'd0);
        do_action(1'b0, mk(1, 32'h10, 10, HASH, 0, 0), 32'h00, 10, 1'b1);

        // Back-to-back pulses: second one is dropped.
        sel = 1'b0;
        @(posedge clk); #1 act_valid = 1'b1; act_data = mk(1, 32'h13, 20, HASH, 0, 1);
        @(posedge clk); #1 act_data = mk(1, 32'h14, 30, HASH, 0, 2);
        @(posedge clk); #1 act_valid = 1'b0;
        @(negedge clk);
        chk("busy_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("busy_nonce_echo", {32'd0, resp_data[63:32]}, 64'd1);
        chk("busy_cmd_target", {32'd0, cmd_target}, 64'h13);
        chk("drop_cnt", {48'd0, drop_cnt}, 64'd1);
        @(posedge clk); @(negedge clk);
        chk("busy_single_resp", {63'd0, resp_valid}, 64'd0);

        // Reset one cycle after the pulse discards the action.
        @(posedge clk); #1 act_valid = 1'b1; act_data = mk(1, 32'h10, 20, HASH, 0, 2);
        @(posedge clk); #1 act_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_resp_t2", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("midrst_resp_t3", {63'd0, resp_valid}, 64'd0);
        chk("midrst_counters", {32'd0, accept_cnt, reject_cnt}, 64'd0);

        // MIN_GAP=4: actions three cycles apart hit RATE; a later one is accepted.
        do_action(1'b1, mk(1, 32'h10, 5, HASH, 0, 0), 32'h00, 5, 1'b1);
        do_action(1'b1, mk(1, 32'h10, 5, HASH, 0, 1), 32'h08, 5, 1'b0);
        repeat (4) @(posedge clk);
        do_action(1'b1, mk(1, 32'h10, 5, HASH, 0, 2), 32'h00, 5, 1'b1);
        @(negedge clk);
        chk("gap_accept_cnt", {48'd0, g_accept_cnt}, 64'd2);
        chk("gap_reject_cnt", {48'd0, g_reject_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
